myo_pid_controller: RTL and testbench

MYO_PID_CONTROLLER -- requirements
Module: myo_pid_controller

---
 rtl/myo_pid_pkg.sv | 23 ++
 rtl/pid_saturate.sv | 38 +++
 rtl/myo_pid_controller.sv | 213 +++++++++++++++++++++
 tb/tb_myo_pid_controller.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/myo_pid_pkg.sv
// myo_pid_pkg: FSM state type, control-mode codes and data widths shared by the PID loop.
package myo_pid_pkg;

    localparam int POS_W  = 32;
    localparam int DATA_W = 16;
    localparam int SUM_W  = 34;

    localparam logic [1:0] MODE_POSITION     = 2'd0;
    localparam logic [1:0] MODE_VELOCITY     = 2'd1;
    localparam logic [1:0] MODE_DISPLACEMENT = 2'd2;
    localparam logic [1:0] MODE_OFF          = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERR,
        ST_PTERM,
        ST_ITERM,
        ST_DTERM,
        ST_SUM,
        ST_OUT
    } pid_state_t;

endpackage

// File: rtl/pid_saturate.sv
// pid_saturate: clamps a signed value to +/-limit, never exceeding the signed OUT_W range.
// A limit of 2**(OUT_W-1) therefore gives plain full-range saturation.
module pid_saturate
    import myo_pid_pkg::*;
#(
    parameter int IN_W  = POS_W,
    parameter int OUT_W = DATA_W
) (
    input  logic signed [IN_W-1:0]  value,
    input  logic        [OUT_W-1:0] limit,
    output logic signed [OUT_W-1:0] result
);

    localparam int CW = IN_W + 2;
    localparam logic signed [CW-1:0] MAX_POS = $signed({{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
    localparam logic signed [CW-1:0] MIN_NEG = ~MAX_POS;

    logic signed [CW-1:0] wide_val;
    logic signed [CW-1:0] lim_ext;
    logic signed [CW-1:0] hi;
    logic signed [CW-1:0] lo;

    // The bounds are worked out in a wider signed domain so the comparison can never wrap.
    always_comb begin
        wide_val = {{(CW-IN_W){value[IN_W-1]}}, value};
        lim_ext  = $signed({{(CW-OUT_W){1'b0}}, limit});
        hi       = (lim_ext > MAX_POS) ? MAX_POS : lim_ext;
        lo       = (-lim_ext < MIN_NEG) ? MIN_NEG : -lim_ext;
        if (wide_val > hi) begin
            result = hi[OUT_W-1:0];
        end else if (wide_val < lo) begin
            result = lo[OUT_W-1:0];
        end else begin
            result = wide_val[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/myo_pid_controller.sv
// myo_pid_controller: sequential PID loop with one shared 16x16 multiplier, triggered by SPI frame completion.
// Optional error deadband is compiled in when PID_DEADBAND_EN is defined.
module myo_pid_controller
    import myo_pid_pkg::*;
#(
    parameter int OUT_SHIFT    = 8,
    parameter int SPI_MODE_OFF = int'(MODE_OFF)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     update,
    input  logic signed [POS_W-1:0]  actual_position,
    input  logic signed [DATA_W-1:0] actual_velocity,
    input  logic signed [DATA_W-1:0] spring_displacement,
    input  logic signed [POS_W-1:0]  setpoint,
    input  logic        [1:0]        control_mode,
    input  logic signed [DATA_W-1:0] kp,
    input  logic signed [DATA_W-1:0] ki,
    input  logic signed [DATA_W-1:0] kd,
    input  logic        [DATA_W-1:0] out_limit,
    input  logic        [DATA_W-1:0] integral_limit,
    input  logic        [DATA_W-1:0] deadband,
    output logic signed [DATA_W-1:0] pwm_ref,
    output logic                     start,
    output logic                     busy
);

    localparam logic [1:0]        OFF_CODE   = 2'(SPI_MODE_OFF);
    localparam logic [DATA_W-1:0] FULL_RANGE = 16'h8000;

    pid_state_t               state;
    logic                     update_q;
    logic [1:0]               mode_q;
    logic signed [DATA_W-1:0] err_q;
    logic signed [DATA_W-1:0] integ;
    logic signed [DATA_W-1:0] last_err;
    logic signed [POS_W-1:0]  p_q;
    logic signed [POS_W-1:0]  i_q;
    logic signed [POS_W-1:0]  d_q;
    logic                     loop_off;

    logic signed [POS_W-1:0]  measured;
    logic signed [POS_W:0]    err_wide;
    logic signed [DATA_W-1:0] err_sat;
    logic signed [DATA_W-1:0] err_final;
    logic signed [DATA_W:0]   integ_sum;
    logic signed [DATA_W-1:0] integ_sat;
    logic signed [DATA_W-1:0] integ_next;
    logic signed [DATA_W:0]   diff_wide;
    logic signed [DATA_W-1:0] diff_sat;
    logic signed [DATA_W-1:0] mul_a;
    logic signed [DATA_W-1:0] mul_b;
    logic signed [POS_W-1:0]  product;
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  sum_shifted;
    logic signed [DATA_W-1:0] out_sat;

    assign loop_off = (mode_q == OFF_CODE);

    always_comb begin
        measured = '0;
        case (control_mode)
            MODE_POSITION:     measured = actual_position;
            MODE_VELOCITY:     measured = {{(POS_W-DATA_W){actual_velocity[DATA_W-1]}}, actual_velocity};
            MODE_DISPLACEMENT: measured = {{(POS_W-DATA_W){spring_displacement[DATA_W-1]}}, spring_displacement};
            default:           measured = '0;
        endcase
    end

    assign err_wide = {setpoint[POS_W-1], setpoint} - {measured[POS_W-1], measured};

    pid_saturate #(.IN_W(POS_W + 1), .OUT_W(DATA_W)) err_clamp (
        .value  (err_wide),
        .limit  (FULL_RANGE),
        .result (err_sat)
    );

`ifdef PID_DEADBAND_EN
    logic [DATA_W:0] err_mag;
    logic            in_band;
    logic            db_hold;

    always_comb begin
        err_mag   = err_sat[DATA_W-1] ? (17'd0 - {1'b1, err_sat}) : {1'b0, err_sat};
        in_band   = (err_mag <= {1'b0, deadband});
        err_final = in_band ? '0 : err_sat;
    end
`else
    logic unused_deadband;

    assign unused_deadband = ^deadband;
    assign err_final       = err_sat;
`endif

    assign integ_sum = {integ[DATA_W-1], integ} + {err_q[DATA_W-1], err_q};

    pid_saturate #(.IN_W(DATA_W + 1), .OUT_W(DATA_W)) integ_clamp (
        .value  (integ_sum),
        .limit  (integral_limit),
        .result (integ_sat)
    );

    always_comb begin
        integ_next = integ_sat;
`ifdef PID_DEADBAND_EN
        if (db_hold) integ_next = integ;
`endif
        if (loop_off) integ_next = '0;
    end

    assign diff_wide = {err_q[DATA_W-1], err_q} - {last_err[DATA_W-1], last_err};

    pid_saturate #(.IN_W(DATA_W + 1), .OUT_W(DATA_W)) diff_clamp (
        .value  (diff_wide),
        .limit  (FULL_RANGE),
        .result (diff_sat)
    );

    // One multiplier serves all three terms; the FSM state picks its operands.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            ST_PTERM: begin mul_a = kp; mul_b = err_q;      end
            ST_ITERM: begin mul_a = ki; mul_b = integ_next; end
            ST_DTERM: begin mul_a = kd; mul_b = diff_sat;   end
            default:  begin mul_a = '0; mul_b = '0;         end
        endcase
    end

    assign product = $signed({{DATA_W{mul_a[DATA_W-1]}}, mul_a} * {{DATA_W{mul_b[DATA_W-1]}}, mul_b});

    assign sum = {{2{p_q[POS_W-1]}}, p_q} + {{2{i_q[POS_W-1]}}, i_q} + {{2{d_q[POS_W-1]}}, d_q};
    assign sum_shifted = sum >>> OUT_SHIFT;

    pid_saturate #(.IN_W(SUM_W), .OUT_W(DATA_W)) out_clamp (
        .value  (sum_shifted),
        .limit  (out_limit),
        .result (out_sat)
    );

    // pwm_ref and start are loaded on the SUM->OUT edge so both are visible during OUT.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            update_q <= 1'b0;
            mode_q   <= '0;
            err_q    <= '0;
            integ    <= '0;
            last_err <= '0;
            p_q      <= '0;
            i_q      <= '0;
            d_q      <= '0;
            pwm_ref  <= '0;
            start    <= 1'b0;
            busy     <= 1'b0;
`ifdef PID_DEADBAND_EN
            db_hold  <= 1'b0;
`endif
        end else begin
            update_q <= update;
            start    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (update && !update_q) begin
                        state <= ST_ERR;
                        busy  <= 1'b1;
                    end
                end
                ST_ERR: begin
                    mode_q <= control_mode;
                    if (control_mode != mode_q) begin
                        integ    <= '0;
                        last_err <= '0;
                    end
                    err_q <= (control_mode == OFF_CODE) ? '0 : err_final;
`ifdef PID_DEADBAND_EN
                    db_hold <= in_band;
`endif
                    state <= ST_PTERM;
                end
                ST_PTERM: begin
                    p_q   <= product;
                    state <= ST_ITERM;
                end
                ST_ITERM: begin
                    integ <= integ_next;
                    i_q   <= product;
                    state <= ST_DTERM;
                end
                ST_DTERM: begin
                    d_q      <= product;
                    last_err <= loop_off ? '0 : err_q;
                    state    <= ST_SUM;
                end
                ST_SUM: begin
                    pwm_ref <= loop_off ? '0 : out_sat;
                    start   <= 1'b1;
                    state   <= ST_OUT;
                end
                ST_OUT: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_myo_pid_controller.sv
// tb_myo_pid_controller: directed vector table, reset/busy corner sequences and a randomized run
// compared against a plain-arithmetic PID model.
module tb_myo_pid_controller;

    logic               clock = 1'b0;
    logic               reset_n;
    logic               update;
    logic signed [31:0] actual_position;
    logic signed [15:0] actual_velocity;
    logic signed [15:0] spring_displacement;
    logic signed [31:0] setpoint;
    logic        [1:0]  control_mode;
    logic signed [15:0] kp;
    logic signed [15:0] ki;
    logic signed [15:0] kd;
    logic        [15:0] out_limit;
    logic        [15:0] integral_limit;
    logic        [15:0] deadband;
    logic signed [15:0] pwm_ref;
    logic               start;
    logic               busy;

    int checks = 0;
    int passed = 0;

    longint     m_integ;
    longint     m_last;
    logic [1:0] m_mode;

`ifdef PID_DEADBAND_EN
    localparam int DB_EXP = 0;
`else
    localparam int DB_EXP = 3;
`endif

    typedef struct {
        int mode;
        int sp;
        int pos;
        int vel;
        int disp;
        int kp;
        int ki;
        int kd;
        int ol;
        int il;
        int db;
        int exp_pwm;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    myo_pid_controller dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .update              (update),
        .actual_position     (actual_position),
        .actual_velocity     (actual_velocity),
        .spring_displacement (spring_displacement),
        .setpoint            (setpoint),
        .control_mode        (control_mode),
        .kp                  (kp),
        .ki                  (ki),
        .kd                  (kd),
        .out_limit           (out_limit),
        .integral_limit      (integral_limit),
        .deadband            (deadband),
        .pwm_ref             (pwm_ref),
        .start               (start),
        .busy                (busy)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string name, input longint actual, input longint expected);
        checks++;
        if (actual == expected) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic apply_stimulus(input vec_t v);
        control_mode        = 2'(v.mode);
        setpoint            = v.sp;
        actual_position     = v.pos;
        actual_velocity     = 16'(v.vel);
        spring_displacement = 16'(v.disp);
        kp                  = 16'(v.kp);
        ki                  = 16'(v.ki);
        kd                  = 16'(v.kd);
        out_limit           = 16'(v.ol);
        integral_limit      = 16'(v.il);
        deadband            = 16'(v.db);
    endtask

    function automatic longint clamp(input longint v, input longint lo, input longint hi);
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    // Reference PID computed directly from the loop's arithmetic rules on the current inputs.
    task automatic model_step(output longint expected);
        longint meas, err, diff, p, i, d, s, lim;
        bit     hold;
        hold = 1'b0;
        if (control_mode != m_mode) begin
            m_integ = 0;
            m_last  = 0;
        end
        m_mode = control_mode;
        if (control_mode == 2'd3) begin
            m_integ  = 0;
            m_last   = 0;
            expected = 0;
        end else begin
            if (control_mode == 2'd0)      meas = longint'(actual_position);
            else if (control_mode == 2'd1) meas = longint'(actual_velocity);
            else                           meas = longint'(spring_displacement);
            err = clamp(longint'(setpoint) - meas, -32768, 32767);
`ifdef PID_DEADBAND_EN
            if (((err < 0) ? -err : err) <= longint'(deadband)) begin
                err  = 0;
                hold = 1'b1;
            end
`endif
            p = longint'(kp) * err;
            lim = clamp(longint'(integral_limit), 0, 32767);
            if (!hold) m_integ = clamp(m_integ + err, -lim, lim);
            i = longint'(ki) * m_integ;
            diff = clamp(err - m_last, -32768, 32767);
            d = longint'(kd) * diff;
            m_last = err;
            s = (p + i + d) >>> 8;
            lim = clamp(longint'(out_limit), 0, 32767);
            expected = clamp(s, -lim, lim);
        end
    endtask

    // One update pulse; busy/start are sampled on each of the seven following edges.
    task automatic run_update(input string name, input longint expected);
        logic [6:0]         start_bits;
        logic [6:0]         busy_bits;
        logic signed [15:0] pwm_at_out;
        pwm_at_out = '0;
        @(negedge clock);
        update = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(posedge clock);
            #1;
            update        = 1'b0;
            start_bits[k] = start;
            busy_bits[k]  = busy;
            if (k == 5) pwm_at_out = pwm_ref;
        end
        check_output({name, "_pwm"}, longint'(pwm_at_out), expected);
        check_output({name, "_timing"}, longint'({busy_bits, start_bits}), longint'({7'b0111111, 7'b0100000}));
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        m_integ = 0;
        m_last  = 0;
        m_mode  = 2'd0;
    endtask

    initial begin
        int     start_count;
        longint expected;
        vec_t   v;

        //              mode  sp       pos  vel disp kp   ki   kd   ol     il     db exp
        vecs[0]  = '{0,    1000,    900, 0,  0,   256, 0,   0,   32767, 32767, 0, 100};
        vecs[1]  = '{0,    100000,  0,   0,  0,   256, 0,   0,   500,   32767, 0, 500};
        vecs[2]  = '{0,    -100000, 0,   0,  0,   256, 0,   0,   500,   32767, 0, -500};
        vecs[3]  = '{0,    1000,    900, 0,  0,   256, 0,   0,   0,     32767, 0, 0};
        vecs[4]  = '{1,    10,      0,   0,  0,   0,   256, 0,   32767, 25,    0, 10};
        vecs[5]  = '{1,    10,      0,   0,  0,   0,   256, 0,   32767, 25,    0, 20};
        vecs[6]  = '{1,    10,      0,   0,  0,   0,   256, 0,   32767, 25,    0, 25};
        vecs[7]  = '{1,    10,      0,   0,  0,   0,   256, 0,   32767, 25,    0, 25};
        vecs[8]  = '{1,    10,      0,   0,  0,   0,   256, 0,   32767, 0,     0, 0};
        vecs[9]  = '{2,    3,       0,   0,  0,   256, 0,   0,   32767, 32767, 5, DB_EXP};
        vecs[10] = '{3,    1000,    900, 50, 7,   256, 256, 256, 32767, 32767, 0, 0};
        vecs[11] = '{0,    50,      0,   0,  0,   0,   256, 0,   32767, 32767, 0, 50};
        vecs[12] = '{0,    70,      0,   0,  0,   0,   0,   256, 32767, 32767, 0, 20};
        vecs[13] = '{0,    -1,      0,   0,  0,   1,   0,   0,   32767, 32767, 0, -1};

        reset_n = 1'b0;
        update  = 1'b0;
        apply_stimulus(vecs[0]);
        m_integ = 0;
        m_last  = 0;
        m_mode  = 2'd0;
        #1;
        check_output("reset_pwm", longint'(pwm_ref), 0);
        check_output("reset_start", longint'(start), 0);
        check_output("reset_busy", longint'(busy), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        for (int n = 0; n < NV; n++) begin
            apply_stimulus(vecs[n]);
            run_update($sformatf("vec%0d", n), longint'(vecs[n].exp_pwm));
        end

        // Reset in the middle of a computation aborts it with no start afterwards.
        apply_stimulus(vecs[0]);
        @(negedge clock);
        update = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            #1;
            update = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        check_output("abort_pwm", longint'(pwm_ref), 0);
        check_output("abort_busy", longint'(busy), 0);
        check_output("abort_start", longint'(start), 0);
        @(negedge clock);
        reset_n = 1'b1;
        start_count = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clock);
            #1;
            if (start) start_count++;
        end
        check_output("abort_no_start", longint'(start_count), 0);

        // A second rising edge while busy is discarded: exactly one start.
        start_count = 0;
        @(negedge clock);
        update = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(posedge clock);
            #1;
            update = (k == 1) || (k == 2);
            if (start) start_count++;
        end
        update = 1'b0;
        check_output("busy_edge_starts", longint'(start_count), 1);
        check_output("busy_edge_pwm", longint'(pwm_ref), 100);

        pulse_reset();
        for (int n = 0; n < 40; n++) begin
            v.mode = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3));
            v.sp   = int'($urandom_range(0, 2000000)) - 1000000;
            v.pos  = int'($urandom_range(0, 2000000)) - 1000000;
            v.vel  = int'($urandom_range(0, 65535));
            v.disp = int'($urandom_range(0, 65535));
            v.kp   = int'($urandom_range(0, 65535));
            v.ki   = int'($urandom_range(0, 65535));
            v.kd   = int'($urandom_range(0, 65535));
            v.ol   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 32767));
            v.il   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 32767));
            v.db   = int'($urandom_range(0, 40));
            if ($urandom_range(0, 3) == 0) v.sp = v.pos + int'($urandom_range(0, 60)) - 30;
            v.exp_pwm = 0;
            apply_stimulus(v);
            model_step(expected);
            run_update($sformatf("rand%0d", n), expected);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
